cpc_rom_loader: RTL and testbench

- Upstream stage of the SDRAM controller's boot port.
- Converts the HPS ioctl download byte stream into paced SDRAM byte writes. Writes are timed to the SDRAM reference strobe (ce_ref).
- Maps system ROM images and expansion ROMs (.eXX, ZZ, Z0) to their SDRAM pages.
- Keeps a 256-entry "upper ROM page present" map, which the memory read mux uses to float absent ROM slots to FF.

---
 rtl/cpc_rom_loader_if.sv | 44 ++++
 rtl/cpc_rom_loader.sv | 196 +++++++++++++++++++
 tb/tb_cpc_rom_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpc_rom_loader_if.sv
// ---------------------------------------------------------------------------
// cpc_rom_loader_if
// Bundles the HPS ioctl download stream and the SDRAM boot-write port used by
// cpc_rom_loader.
//   master : download source / SDRAM side (drives ioctl_*, receives boot_*)
//   slave  : the loader (receives ioctl_*, drives ioctl_wait and boot_*)
// Signals:
//   ioctl_download  download active
//   ioctl_wr        byte strobe
//   ioctl_addr      byte offset in file
//   ioctl_dout      byte data
//   ioctl_index     0 = boot ROM set, nonzero = expansion ROM
//   ioctl_file_ext  last two extension chars, ASCII, [15:8] first
//   ioctl_wait      stall back to the HPS
//   boot_wr         SDRAM write request
//   boot_a          SDRAM byte address, [22] = upper-ROM region
//   boot_bank       SDRAM bank
//   boot_dout       SDRAM write data
// ---------------------------------------------------------------------------
interface cpc_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [15:0] ioctl_file_ext;
  logic        ioctl_wait;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [1:0]  boot_bank;
  logic [7:0]  boot_dout;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
           ioctl_file_ext,
    input  ioctl_wait, boot_wr, boot_a, boot_bank, boot_dout
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
           ioctl_file_ext,
    output ioctl_wait, boot_wr, boot_a, boot_bank, boot_dout
  );
endinterface

// File: rtl/cpc_rom_loader.sv
// ---------------------------------------------------------------------------
// cpc_rom_loader
// Turns the HPS ioctl byte stream into SDRAM byte writes paced by ce_ref,
// maps boot and expansion ROM images onto their SDRAM pages, and keeps a
// 256-bit "upper ROM present" map for the memory read mux.
// Ports:
//   clk_sys      system clock
//   reset        synchronous active-high reset (power-on / user only)
//   ce_ref       SDRAM reference strobe, one clk_sys wide
//   bus          ioctl download + SDRAM boot-write port (slave side)
//   map_addr     upper ROM number being looked up
//   rom_present  map[map_addr], one cycle latency
// ---------------------------------------------------------------------------
module cpc_rom_loader #(
  parameter logic [8:0] MF2_PAGE = 9'h1FF,
  parameter logic [8:0] BAD_PAGE = 9'h1EE
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce_ref,
  cpc_rom_loader_if.slave        bus,
  input  logic [7:0]             map_addr,
  output logic                   rom_present
);

  typedef enum logic [1:0] {IDLE, ARM, WRITE} state_t;

  state_t       state_q;
  logic [8:0]   page_q;
  logic         combo_q;
  logic         dl_q;
  logic         dual_q;
  logic         wait_q;
  logic         wr_q;
  logic [22:0]  a_q;
  logic [1:0]   bank_q;
  logic [7:0]   dout_q;
  logic [255:0] map_q;
  logic         present_q;

  // Hex digit decode: {valid, nibble}.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [7:0] d;
    if (c >= 8'h30 && c <= 8'h39) begin
      d = c - 8'h30;
      return {1'b1, d[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      d = c - 8'h37;
      return {1'b1, d[3:0]};
    end
    return 5'd0;
  endfunction

  // Expansion page selection from the file extension.
  logic [4:0] hi_nib_d;
  logic [4:0] lo_nib_d;
  logic [8:0] ext_page_d;
  logic       ext_combo_d;
  logic       latch_page_d;
  logic [8:0] page_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hi_nib_d    = hex_nib(bus.ioctl_file_ext[15:8]);
    lo_nib_d    = hex_nib(bus.ioctl_file_ext[7:0]);
    ext_page_d  = BAD_PAGE;
    ext_combo_d = 1'b0;
    if (bus.ioctl_file_ext == 16'h5A5A) begin          // "ZZ"
      ext_page_d = 9'h000;
    end else if (bus.ioctl_file_ext == 16'h5A30) begin // "Z0"
      ext_page_d  = 9'h000;
      ext_combo_d = 1'b1;
    end else begin
      if (hi_nib_d[4]) ext_page_d[7:4] = hi_nib_d[3:0];
      if (lo_nib_d[4]) ext_page_d[3:0] = lo_nib_d[3:0];
      ext_page_d[8] = 1'b1;
    end
  end

  assign latch_page_d = bus.ioctl_download & ~dl_q & (bus.ioctl_index != 8'd0);
  // A byte arriving on the very cycle the download starts must already see
  // the new page.
  assign page_d = latch_page_d ? ext_page_d : page_q;

  // Target address / bank of the incoming byte.
  logic [10:0] blk_d;
  logic [8:0]  boot_page_d;
  logic [7:0]  upper_pg_d;
  logic [22:0] req_a_d;
  logic [1:0]  req_bank_d;
  logic        req_dual_d;
  logic        req_ok_d;

  assign blk_d      = bus.ioctl_addr[24:14];
  assign upper_pg_d = page_d[7:0] + bus.ioctl_addr[21:14];  // wraps mod 256

  always_comb begin
    boot_page_d = 9'h000;
    req_a_d     = '0;
    req_bank_d  = 2'd0;
    req_dual_d  = 1'b0;
    req_ok_d    = 1'b1;
    if (bus.ioctl_index == 8'd0) begin
      case (blk_d[1:0])
        2'd0:    boot_page_d = 9'h000;
        2'd1:    boot_page_d = 9'h100;
        2'd2:    boot_page_d = 9'h107;
        default: boot_page_d = MF2_PAGE;
      endcase
      req_ok_d   = (blk_d[10:3] == 8'd0);
      req_a_d    = {boot_page_d, bus.ioctl_addr[13:0]};
      req_bank_d = {1'b0, blk_d[2]};
    end else begin
      req_a_d    = {page_d[8], upper_pg_d, bus.ioctl_addr[13:0]};
      req_dual_d = (bus.ioctl_index[7:6] == 2'b01) || (bus.ioctl_index[5:0] != 6'd0);
      req_bank_d = req_dual_d ? 2'd0 : {1'b0, &bus.ioctl_index[7:6]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 9'h000;
      combo_q <= 1'b0;
      dl_q    <= 1'b0;
      dual_q  <= 1'b0;
      wait_q  <= 1'b0;
      wr_q    <= 1'b0;
      a_q     <= '0;
      bank_q  <= 2'd0;
      dout_q  <= 8'd0;
      // NOTE: the map is a flop vector, not RAM, because the read mux needs
      // every slot to read absent straight after reset.
      map_q   <= '0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (latch_page_d) begin
        page_q  <= ext_page_d;
        combo_q <= ext_combo_d;
      end
      case (state_q)
        IDLE: begin
          // Bytes outside the boot set are dropped without stalling.
          if (bus.ioctl_download && bus.ioctl_wr && req_ok_d) begin
            a_q     <= req_a_d;
            bank_q  <= req_bank_d;
            dout_q  <= bus.ioctl_dout;
            dual_q  <= req_dual_d;
            wait_q  <= 1'b1;
            state_q <= ARM;
          end
        end
        ARM: begin
          if (ce_ref) begin
            wr_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (ce_ref) begin
            if (dual_q && bank_q == 2'd0) begin
              bank_q <= 2'd1;
            end else begin
              wr_q    <= 1'b0;
              wait_q  <= 1'b0;
              state_q <= IDLE;
              if (a_q[22]) map_q[a_q[21:14]] <= 1'b1;
              // Combo image: after the lower ROM half, jump to page 0x1FF so
              // the wrapping add lands the rest at upper pages 0x00, 0x01, ...
              if (combo_q && a_q[13:0] == 14'h3FFF) begin
                combo_q <= 1'b0;
                page_q  <= 9'h1FF;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) present_q <= 1'b0;
    else       present_q <= map_q[map_addr];
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.boot_wr    = wr_q;
  assign bus.boot_a     = a_q;
  assign bus.boot_bank  = bank_q;
  assign bus.boot_dout  = dout_q;
  assign rom_present    = present_q;

endmodule

// File: tb/tb_cpc_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_cpc_rom_loader
// Directed bench for cpc_rom_loader: boot-set mapping, expansion pages,
// dual-bank writes, combo (Z0) handling, bad extensions, reset mid-write and
// the ROM-present map.
// ---------------------------------------------------------------------------
module tb_cpc_rom_loader;

  logic       clk_sys;
  logic       reset;
  logic       ce_ref;
  logic [7:0] map_addr;
  logic       rom_present;

  int n_checks = 0;
  int n_errors = 0;
  int ce_cnt   = 0;

  cpc_rom_loader_if bus();

  cpc_rom_loader dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce_ref      (ce_ref),
    .bus         (bus),
    .map_addr    (map_addr),
    .rom_present (rom_present)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // One-cycle ce_ref every 16 clocks, changed on the falling edge.
  initial begin
    ce_ref = 1'b0;
    forever begin
      @(negedge clk_sys);
      ce_cnt = (ce_cnt + 1) % 16;
      ce_ref = (ce_cnt == 0);
    end
  end

  initial begin
    #300us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic begin_dl(input logic [7:0] index, input logic [15:0] ext);
    @(negedge clk_sys);
    bus.ioctl_index    = index;
    bus.ioctl_file_ext = ext;
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic check_map(input string tag, input logic [7:0] addr, input logic exp);
    @(negedge clk_sys);
    map_addr = addr;
    @(negedge clk_sys);
    check(tag, {31'd0, rom_present}, {31'd0, exp});
  endtask

  // Sends one byte and watches the resulting write sequence.
  task automatic send_byte(input string tag, input logic [24:0] addr,
                           input logic [7:0] data, input int exp_writes,
                           input logic [22:0] exp_a, input logic [1:0] exp_bank0,
                           input bit spurious);
    int         wait_cyc = 0;
    int         nwr      = 0;
    logic       prev_wr  = 1'b0;
    logic [1:0] prev_bank = 2'd0;
    logic [22:0] a_seen[2];
    logic [1:0]  b_seen[2];
    logic [7:0]  d_seen[2];
    int          len_seen[2];
    for (int i = 0; i < 2; i++) begin
      a_seen[i] = '0; b_seen[i] = '0; d_seen[i] = '0; len_seen[i] = 0;
    end
    @(negedge clk_sys);
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr   = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (spurious && c == 3) begin
        bus.ioctl_dout = ~data;
        bus.ioctl_wr   = 1'b1;
      end else begin
        bus.ioctl_wr   = 1'b0;
      end
      if (bus.ioctl_wait) wait_cyc++;
      if (bus.boot_wr && (!prev_wr || bus.boot_bank != prev_bank)) begin
        if (nwr < 2) begin
          a_seen[nwr] = bus.boot_a;
          b_seen[nwr] = bus.boot_bank;
          d_seen[nwr] = bus.boot_dout;
        end
        nwr++;
      end
      if (bus.boot_wr && nwr > 0 && nwr <= 2) len_seen[nwr-1]++;
      prev_wr   = bus.boot_wr;
      prev_bank = bus.boot_bank;
      if (wait_cyc > 0 && !bus.ioctl_wait) break;
      @(negedge clk_sys);
    end
    bus.ioctl_wr   = 1'b0;
    bus.ioctl_dout = data;
    check({tag, "_nwr"}, nwr, exp_writes);
    if (exp_writes == 0) begin
      check({tag, "_wait"}, wait_cyc, 0);
    end else begin
      check({tag, "_a0"}, {9'd0, a_seen[0]}, {9'd0, exp_a});
      check({tag, "_bank0"}, {30'd0, b_seen[0]}, {30'd0, exp_bank0});
      check({tag, "_dout0"}, {24'd0, d_seen[0]}, {24'd0, data});
      check({tag, "_len0"}, len_seen[0], 16);
    end
    if (exp_writes == 1)
      check({tag, "_wait_range"}, {31'd0, (wait_cyc >= 17 && wait_cyc <= 32)}, 1);
    if (exp_writes == 2) begin
      check({tag, "_a1"}, {9'd0, a_seen[1]}, {9'd0, exp_a});
      check({tag, "_bank1"}, {30'd0, b_seen[1]}, 32'd1);
      check({tag, "_len1"}, len_seen[1], 16);
      check({tag, "_wait_range"}, {31'd0, (wait_cyc >= 33 && wait_cyc <= 48)}, 1);
    end
  endtask

  initial begin
    bit seen;
    reset              = 1'b1;
    map_addr           = 8'd0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = 8'd0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_file_ext = 16'd0;
    repeat (3) @(negedge clk_sys);

    // Reset state.
    check("rst_wait",    {31'd0, bus.ioctl_wait}, 0);
    check("rst_wr",      {31'd0, bus.boot_wr}, 0);
    check("rst_a",       {9'd0, bus.boot_a}, 0);
    check("rst_bank",    {30'd0, bus.boot_bank}, 0);
    check("rst_dout",    {24'd0, bus.boot_dout}, 0);
    check("rst_present", {31'd0, rom_present}, 0);
    reset = 1'b0;

    // Boot ROM set.
    begin_dl(8'h00, 16'h0000);
    send_byte("boot_k2", 25'h0_8123, 8'hA5, 1, 23'h41C123, 2'd0, 1'b0);
    send_byte("boot_k3", 25'h0_C123, 8'h5A, 1, 23'h7FC123, 2'd0, 1'b0);
    send_byte("boot_k4", 25'h1_0010, 8'h11, 1, 23'h000010, 2'd1, 1'b0);
    send_byte("boot_k8", 25'h2_0000, 8'h22, 0, 23'h0, 2'd0, 1'b0);
    end_dl();
    check_map("map_07_boot", 8'h07, 1'b1);
    check_map("map_ff_boot", 8'hFF, 1'b1);
    check_map("map_00_boot", 8'h00, 1'b0);

    // Reset while in WRITE.
    begin_dl(8'h00, 16'h0000);
    @(negedge clk_sys);
    bus.ioctl_addr = 25'h0_8123;
    bus.ioctl_dout = 8'h77;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr   = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.boot_wr) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    check("rstw_reached_write", {31'd0, seen}, 1);
    reset = 1'b1;
    @(negedge clk_sys);
    check("rstw_wr",   {31'd0, bus.boot_wr}, 0);
    check("rstw_wait", {31'd0, bus.ioctl_wait}, 0);
    reset = 1'b0;
    bus.ioctl_download = 1'b0;
    check_map("rstw_map_07", 8'h07, 1'b0);
    check_map("rstw_map_ff", 8'hFF, 1'b0);

    // Expansion, dual write, ext "07".
    begin_dl(8'h41, 16'h3037);
    send_byte("exp41", 25'h0_0005, 8'hC3, 2, 23'h41C005, 2'd0, 1'b0);
    end_dl();
    check_map("map_07_exp", 8'h07, 1'b1);

    // Combo image "Z0", single write (index 0x80).
    begin_dl(8'h80, 16'h5A30);
    send_byte("z0_lo", 25'h0_3FFF, 8'h01, 1, 23'h003FFF, 2'd0, 1'b0);
    check_map("map_00_after_lo", 8'h00, 1'b0);
    send_byte("z0_up0", 25'h0_4000, 8'h02, 1, 23'h400000, 2'd0, 1'b0);
    send_byte("z0_up1", 25'h0_8001, 8'h03, 1, 23'h404001, 2'd0, 1'b0);
    end_dl();
    check_map("map_00_z0", 8'h00, 1'b1);
    check_map("map_01_z0", 8'h01, 1'b1);

    // Malformed extension "QX" with a spurious strobe during the stall.
    begin_dl(8'h80, 16'h5158);
    send_byte("qx", 25'h0_0010, 8'h3C, 1, 23'h7B8010, 2'd0, 1'b1);
    end_dl();
    check_map("map_ee_qx", 8'hEE, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
